// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store reservation buffer for the Tomasulo
// datapath. It sits directly upstream of the memory unit.
//   - Accepts memory ops from issue into a circular buffer of DEPTH entries.
//   - Snoops the CDB until the base (Vj) and store-data (Vk) operands resolve.
//   - Dispatches the head op, strictly in program order, with a one-cycle nova
//     strobe. The effective address is (Vj + imm) truncated to 8 bits.
// Ports:
//   clock, reset             clock; synchronous active-high reset
//   issue_*                  op presented by the issue stage (op/dest/tag/imm/vj/qj/vk/qk)
//   full, count              occupancy (full is combinational from count)
//   cdb_valid/tag/value      common data bus broadcast
//   A, data, W               registered memory address, store data, write enable
//   dest_out, Qi_out,        registered attributes of the dispatched op
//   opcode_out
//   nova                     registered one-cycle dispatch strobe
//   stall_cnt                saturating count of cycles the head was blocked
//                            (present only when LSB_STALL_CNT_EN is defined)
// Build option: define LSB_STALL_CNT_EN to add the stall_cnt output.
module load_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [1:0]        issue_op,
  input  logic [2:0]        issue_dest,
  input  logic [3:0]        issue_tag,
  input  logic [7:0]        issue_imm,
  input  logic [15:0]       issue_vj,
  input  logic [3:0]        issue_qj,
  input  logic [15:0]       issue_vk,
  input  logic [3:0]        issue_qk,
  output logic              full,
  output logic [PTR_W:0]    count,
  input  logic              cdb_valid,
  input  logic [3:0]        cdb_tag,
  input  logic [15:0]       cdb_value,
  output logic [7:0]        A,
  output logic [15:0]       data,
  output logic              W,
  output logic [2:0]        dest_out,
  output logic [3:0]        Qi_out,
  output logic [1:0]        opcode_out,
  output logic              nova
`ifdef LSB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [1:0] OP_STORE = 2'b11;

  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic [2:0]  dest;
    logic [3:0]  tag;
    logic [7:0]  imm;
    logic [15:0] vj;
    logic [3:0]  qj;
    logic [15:0] vk;
    logic [3:0]  qk;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [7:0]       a_q, a_d;
  logic [15:0]      data_q, data_d;
  logic             w_q, w_d;
  logic [2:0]       dest_q, dest_d;
  logic [3:0]       qi_q, qi_d;
  logic [1:0]       opc_q, opc_d;
  logic             nova_q, nova_d;

  entry_t           head_e;
  logic             head_ready;
  logic             issue_fire;
  logic [15:0]      ea_sum;

`ifdef LSB_STALL_CNT_EN
  logic [15:0]      stall_q, stall_d;
`endif

  assign full = (count_q == (PTR_W+1)'(DEPTH));

  // Head readiness looks only at registered state; loads ignore Qk.
  always_comb begin
    head_e     = ent_q[head_q];
    head_ready = head_e.valid && (head_e.qj == 4'd0) &&
                 ((head_e.op != OP_STORE) || (head_e.qk == 4'd0));
    issue_fire = issue_valid && !full;
    ea_sum     = head_e.vj + 16'(head_e.imm);
  end

  // Next state: snoop, dispatch head, write tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    a_d     = a_q;
    data_d  = data_q;
    w_d     = w_q;
    dest_d  = dest_q;
    qi_d    = qi_q;
    opc_d   = opc_q;
    nova_d  = 1'b0;

    // CDB snoop on resident entries
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && cdb_valid && (cdb_tag != 4'd0)) begin
        if (ent_q[i].qj == cdb_tag) begin
          ent_d[i].vj = cdb_value;
          ent_d[i].qj = 4'd0;
        end
        if (ent_q[i].qk == cdb_tag) begin
          ent_d[i].vk = cdb_value;
          ent_d[i].qk = 4'd0;
        end
      end
    end

    if (head_ready) begin
      a_d                 = ea_sum[7:0];
      data_d              = head_e.vk;
      w_d                 = (head_e.op == OP_STORE);
      dest_d              = head_e.dest;
      qi_d                = head_e.tag;
      opc_d               = head_e.op;
      nova_d              = 1'b1;
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end

    // Tail slot is never the dispatching head: full blocks issue when occupied.
    if (issue_fire) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].op    = issue_op;
      ent_d[tail_q].dest  = issue_dest;
      ent_d[tail_q].tag   = issue_tag;
      ent_d[tail_q].imm   = issue_imm;
      ent_d[tail_q].vj    = issue_vj;
      ent_d[tail_q].qj    = issue_qj;
      ent_d[tail_q].vk    = issue_vk;
      ent_d[tail_q].qk    = issue_qk;
      // Forward a same-cycle broadcast into the new entry
      if (cdb_valid && (issue_qj != 4'd0) && (issue_qj == cdb_tag)) begin
        ent_d[tail_q].vj = cdb_value;
        ent_d[tail_q].qj = 4'd0;
      end
      if (cdb_valid && (issue_qk != 4'd0) && (issue_qk == cdb_tag)) begin
        ent_d[tail_q].vk = cdb_value;
        ent_d[tail_q].qk = 4'd0;
      end
      tail_d = tail_q + PTR_W'(1);
    end

    count_d = count_q + (PTR_W+1)'(issue_fire) - (PTR_W+1)'(head_ready);
  end

`ifdef LSB_STALL_CNT_EN
  // Saturating count of cycles the head is occupied but blocked
  always_comb begin
    stall_d = stall_q;
    if (head_e.valid && !head_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end
`endif

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      a_q     <= '0;
      data_q  <= '0;
      w_q     <= 1'b0;
      dest_q  <= '0;
      qi_q    <= '0;
      opc_q   <= '0;
      nova_q  <= 1'b0;
`ifdef LSB_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      a_q     <= a_d;
      data_q  <= data_d;
      w_q     <= w_d;
      dest_q  <= dest_d;
      qi_q    <= qi_d;
      opc_q   <= opc_d;
      nova_q  <= nova_d;
`ifdef LSB_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign count      = count_q;
  assign A          = a_q;
  assign data       = data_q;
  assign W          = w_q;
  assign dest_out   = dest_q;
  assign Qi_out     = qi_q;
  assign opcode_out = opc_q;
  assign nova       = nova_q;
`ifdef LSB_STALL_CNT_EN
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer: directed self-checking bench for load_store_buffer.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_load_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [2:0]  issue_dest;
  logic [3:0]  issue_tag;
  logic [7:0]  issue_imm;
  logic [15:0] issue_vj;
  logic [3:0]  issue_qj;
  logic [15:0] issue_vk;
  logic [3:0]  issue_qk;
  logic        full;
  logic [2:0]  count;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic [7:0]  A;
  logic [15:0] data;
  logic        W;
  logic [2:0]  dest_out;
  logic [3:0]  Qi_out;
  logic [1:0]  opcode_out;
  logic        nova;
`ifdef LSB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  load_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_dest(issue_dest),
    .issue_tag(issue_tag), .issue_imm(issue_imm), .issue_vj(issue_vj),
    .issue_qj(issue_qj), .issue_vk(issue_vk), .issue_qk(issue_qk),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .A(A), .data(data), .W(W), .dest_out(dest_out), .Qi_out(Qi_out),
    .opcode_out(opcode_out), .nova(nova)
`ifdef LSB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    cdb_tag     = 4'd0;
    cdb_value   = 16'd0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] dest, input logic [3:0] tag,
                       input logic [7:0] imm, input logic [15:0] vj, input logic [3:0] qj,
                       input logic [15:0] vk, input logic [3:0] qk);
    issue_valid = 1'b1;
    issue_op = op; issue_dest = dest; issue_tag = tag; issue_imm = imm;
    issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [15:0] value);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    issue(2'b10, 3'd0, 4'd1, 8'd0, 16'd0, 4'd0, 16'd0, 4'd0);
    tick(); tick();
    checks++; if (nova !== 1'b0) begin errors++; $display("FAIL reset_nova got %0b exp 0", nova); end
    checks++; if (A !== 8'h00) begin errors++; $display("FAIL reset_A got %h exp 00", A); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
    idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ready_load();
    issue(2'b10, 3'd1, 4'd4, 8'h05, 16'h0010, 4'd0, 16'h1234, 4'd9);
    tick();
    idle();
    checks++; if (nova !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL load_issue nova=%0b count=%0d exp 0/1", nova, count); end
    tick();
    checks++; if (nova !== 1'b1) begin errors++; $display("FAIL load_nova got %0b exp 1", nova); end
    checks++; if (A !== 8'h15 || W !== 1'b0) begin errors++; $display("FAIL load_addr A=%h W=%0b exp 15/0", A, W); end
    checks++; if (Qi_out !== 4'd4 || dest_out !== 3'd1 || opcode_out !== 2'b10) begin
      errors++; $display("FAIL load_attr Qi=%0d dest=%0d op=%b exp 4/1/10", Qi_out, dest_out, opcode_out); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL load_count got %0d exp 0", count); end
    tick();
    checks++; if (nova !== 1'b0 || A !== 8'h15) begin errors++; $display("FAIL load_hold nova=%0b A=%h exp 0/15", nova, A); end
  endtask

  task automatic test_waiting_store();
    issue(2'b11, 3'd2, 4'd9, 8'h08, 16'h0000, 4'd3, 16'h0000, 4'd5);
    tick();
    idle();
    tick();
    checks++; if (nova !== 1'b0) begin errors++; $display("FAIL store_wait got %0b exp 0", nova); end
    cdb(4'd3, 16'h0020);
    tick();
    checks++; if (nova !== 1'b0) begin errors++; $display("FAIL store_after_vj got %0b exp 0", nova); end
    cdb(4'd5, 16'hBEEF);
    tick();
    idle();
    checks++; if (nova !== 1'b0) begin errors++; $display("FAIL store_same_edge got %0b exp 0", nova); end
    tick();
    checks++; if (nova !== 1'b1) begin errors++; $display("FAIL store_nova got %0b exp 1", nova); end
    checks++; if (A !== 8'h28 || data !== 16'hBEEF || W !== 1'b1) begin
      errors++; $display("FAIL store_out A=%h data=%h W=%0b exp 28/BEEF/1", A, data, W); end
    checks++; if (Qi_out !== 4'd9 || opcode_out !== 2'b11) begin errors++; $display("FAIL store_attr Qi=%0d op=%b exp 9/11", Qi_out, opcode_out); end
  endtask

  task automatic test_order();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    issue(2'b10, 3'd3, 4'd1, 8'h01, 16'h0000, 4'd7, 16'h0000, 4'd0);
    tick();
    issue(2'b10, 3'd4, 4'd2, 8'h02, 16'h0100, 4'd0, 16'h0000, 4'd0);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (nova !== 1'b0) begin errors++; $display("FAIL order_blocked cycle %0d got %0b exp 0", i, nova); end
    end
    cdb(4'd7, 16'h0030);
    tick();
    idle();
    checks++; if (nova !== 1'b0) begin errors++; $display("FAIL order_cdb_edge got %0b exp 0", nova); end
    tick();
    checks++; if (nova !== 1'b1 || Qi_out !== 4'd1 || A !== 8'h31) begin
      errors++; $display("FAIL order_first nova=%0b Qi=%0d A=%h exp 1/1/31", nova, Qi_out, A); end
    tick();
    checks++; if (nova !== 1'b1 || Qi_out !== 4'd2 || A !== 8'h02) begin
      errors++; $display("FAIL order_second nova=%0b Qi=%0d A=%h exp 1/2/02", nova, Qi_out, A); end
`ifdef LSB_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL order_stall_cnt got %0d exp 4", stall_cnt); end
`endif
    tick();
    checks++; if (nova !== 1'b0) begin errors++; $display("FAIL order_done got %0b exp 0", nova); end
  endtask

  task automatic test_full();
    logic [3:0] exp_tag [4];
    int         seen;
    exp_tag[0] = 4'd1; exp_tag[1] = 4'd2; exp_tag[2] = 4'd3; exp_tag[3] = 4'd4;
    issue(2'b10, 3'd0, 4'd1, 8'h00, 16'h0000, 4'd8, 16'h0000, 4'd0);
    tick();
    for (int i = 2; i <= 5; i++) begin
      issue(2'b10, 3'(i), 4'(i), 8'(i), 16'h0000, 4'd0, 16'h0000, 4'd0);
      tick();
      if (i == 3) begin
        checks++; if (count !== 3'd3 || full !== 1'b0) begin errors++; $display("FAIL full_three count=%0d full=%0b exp 3/0", count, full); end
      end
      if (i == 4) begin
        checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_four count=%0d full=%0b exp 4/1", count, full); end
      end
    end
    idle();
    checks++; if (count !== 3'd4 || full !== 1'b1 || nova !== 1'b0) begin
      errors++; $display("FAIL full_drop count=%0d full=%0b nova=%0b exp 4/1/0", count, full, nova); end
    cdb(4'd8, 16'h0040);
    tick();
    idle();
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (nova === 1'b1) begin
        if (seen < 4) begin
          checks++; if (Qi_out !== exp_tag[seen]) begin errors++; $display("FAIL full_order idx %0d got %0d exp %0d", seen, Qi_out, exp_tag[seen]); end
        end
        seen++;
      end
    end
    checks++; if (seen !== 4) begin errors++; $display("FAIL full_dispatches got %0d exp 4", seen); end
    checks++; if (count !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL full_drain count=%0d full=%0b exp 0/0", count, full); end
  endtask

  task automatic test_back_to_back();
    issue(2'b10, 3'd1, 4'd10, 8'h01, 16'h0000, 4'd0, 16'h0000, 4'd0);
    tick();
    issue(2'b11, 3'd2, 4'd11, 8'h02, 16'h0000, 4'd0, 16'hCAFE, 4'd0);
    tick();
    checks++; if (nova !== 1'b1 || Qi_out !== 4'd10 || count !== 3'd1) begin
      errors++; $display("FAIL b2b_first nova=%0b Qi=%0d count=%0d exp 1/10/1", nova, Qi_out, count); end
    issue(2'b01, 3'd3, 4'd12, 8'h03, 16'h0000, 4'd0, 16'h0000, 4'd0);
    tick();
    idle();
    checks++; if (nova !== 1'b1 || Qi_out !== 4'd11 || W !== 1'b1 || data !== 16'hCAFE || count !== 3'd1) begin
      errors++; $display("FAIL b2b_second nova=%0b Qi=%0d W=%0b data=%h count=%0d exp 1/11/1/CAFE/1", nova, Qi_out, W, data, count); end
    tick();
    checks++; if (nova !== 1'b1 || Qi_out !== 4'd12 || W !== 1'b0 || opcode_out !== 2'b01 || count !== 3'd0) begin
      errors++; $display("FAIL b2b_third nova=%0b Qi=%0d W=%0b op=%b count=%0d exp 1/12/0/01/0", nova, Qi_out, W, opcode_out, count); end
    tick();
  endtask

  task automatic test_edge();
    issue(2'b10, 3'd5, 4'd13, 8'h01, 16'h0000, 4'd6, 16'h0000, 4'd0);
    cdb(4'd6, 16'h00FF);
    tick();
    issue(2'b10, 3'd6, 4'd14, 8'h20, 16'hFFF0, 4'd0, 16'h0000, 4'd0);
    cdb_valid = 1'b0;
    tick();
    idle();
    checks++; if (nova !== 1'b1 || Qi_out !== 4'd13 || A !== 8'h00) begin
      errors++; $display("FAIL edge_forward nova=%0b Qi=%0d A=%h exp 1/13/00", nova, Qi_out, A); end
    tick();
    checks++; if (nova !== 1'b1 || A !== 8'h10) begin errors++; $display("FAIL edge_wrap nova=%0b A=%h exp 1/10", nova, A); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(2'b10, 3'd0, 4'd15, 8'h00, 16'h0000, 4'd0, 16'h0000, 4'd0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    checks++; if (nova !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL reset_mid nova=%0b count=%0d exp 0/0", nova, count); end
    reset = 1'b0;
    tick();
    checks++; if (nova !== 1'b0) begin errors++; $display("FAIL reset_mid_after got %0b exp 0", nova); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    issue_op = '0; issue_dest = '0; issue_tag = '0; issue_imm = '0;
    issue_vj = '0; issue_qj = '0; issue_vk = '0; issue_qk = '0;
    test_reset();
    test_ready_load();
    test_waiting_store();
    test_order();
    test_full();
    test_back_to_back();
    test_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
